// File: rtl/bpu_train_queue.sv
// Branch-predictor training queue: captures two retire lanes per cycle, issues frontend redirects,
// and drains one entry per cycle to the predictor update ports. Optional counters: BPU_TRAIN_PERF_EN.
module bpu_train_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_0,
    input  logic        in_valid_1,
    input  logic [31:0] in_pc_0,
    input  logic [31:0] in_pc_1,
    input  logic [2:0]  in_type_0,
    input  logic [2:0]  in_type_1,
    input  logic        in_pred_taken_0,
    input  logic        in_pred_taken_1,
    input  logic [31:0] in_pred_target_0,
    input  logic [31:0] in_pred_target_1,
    input  logic        in_act_taken_0,
    input  logic        in_act_taken_1,
    input  logic [31:0] in_act_target_0,
    input  logic [31:0] in_act_target_1,
    output logic        in_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        branch_mistaken,
    output logic [31:0] wrong_pc,
    output logic [31:0] right_target,
    output logic [2:0]  ins_type_w,
    output logic        update_orien_en,
    output logic [31:0] retire_pc,
    output logic        right_orien
`ifdef BPU_TRAIN_PERF_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] TYPE_COND = 3'b101;

    logic [CW-1:0] count_reg;
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;

    logic [31:0] pc_mem     [DEPTH];
    logic [31:0] target_mem [DEPTH];
    logic [2:0]  type_mem   [DEPTH];
    logic        taken_mem  [DEPTH];
    logic        mp_mem     [DEPTH];

    logic [1:0]  lane_valid;
    logic [31:0] lane_pc          [2];
    logic [2:0]  lane_type        [2];
    logic [1:0]  lane_pred_taken;
    logic [31:0] lane_pred_target [2];
    logic [1:0]  lane_act_taken;
    logic [31:0] lane_act_target  [2];
    logic [1:0]  lane_eff_taken;
    logic [1:0]  lane_mp;
    logic [31:0] lane_redirect_pc [2];
    logic [AW-1:0] lane_addr      [2];

    logic [1:0]  acc;
    logic        deq;
    logic        redirect_next;

    assign lane_valid       = {in_valid_1, in_valid_0};
    assign lane_pc[0]       = in_pc_0;
    assign lane_pc[1]       = in_pc_1;
    assign lane_type[0]     = in_type_0;
    assign lane_type[1]     = in_type_1;
    assign lane_pred_taken  = {in_pred_taken_1, in_pred_taken_0};
    assign lane_pred_target[0] = in_pred_target_0;
    assign lane_pred_target[1] = in_pred_target_1;
    assign lane_act_taken   = {in_act_taken_1, in_act_taken_0};
    assign lane_act_target[0]  = in_act_target_0;
    assign lane_act_target[1]  = in_act_target_1;

    assign in_ready = (count_reg <= CW'(DEPTH - 2));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // Unconditional transfers (direct/call/ret/indirect) always resolve taken.
            assign lane_eff_taken[gi] = ((lane_type[gi] >= 3'b001) && (lane_type[gi] <= 3'b100))
                                        ? 1'b1 : lane_act_taken[gi];
            assign lane_mp[gi] = (lane_pred_taken[gi] != lane_eff_taken[gi]) ||
                                 (lane_eff_taken[gi] && (lane_pred_target[gi] != lane_act_target[gi]));
            assign lane_redirect_pc[gi] = lane_eff_taken[gi] ? lane_act_target[gi]
                                                             : lane_pc[gi] + 32'd4;
        end
    endgenerate

    always_comb begin
        acc    = 2'b00;
        acc[0] = lane_valid[0] && in_ready && (lane_type[0] != 3'b000);
        // A mispredicting older lane squashes the younger one.
        acc[1] = lane_valid[1] && in_ready && (lane_type[1] != 3'b000) && !(acc[0] && lane_mp[0]);
        lane_addr[0]  = wptr_reg;
        lane_addr[1]  = wptr_reg + AW'(acc[0]);
        deq           = (count_reg != '0);
        redirect_next = (acc[0] && lane_mp[0]) || (acc[1] && lane_mp[1]);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                pc_mem[lane_addr[i]]     <= lane_pc[i];
                target_mem[lane_addr[i]] <= lane_act_target[i];
                type_mem[lane_addr[i]]   <= lane_type[i];
                taken_mem[lane_addr[i]]  <= lane_eff_taken[i];
                mp_mem[lane_addr[i]]     <= lane_mp[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
        end else begin
            count_reg <= count_reg + CW'(acc[0]) + CW'(acc[1]) - CW'(deq);
            wptr_reg  <= wptr_reg + AW'(acc[0]) + AW'(acc[1]);
            rptr_reg  <= rptr_reg + AW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            branch_mistaken <= 1'b0;
            wrong_pc        <= '0;
            right_target    <= '0;
            ins_type_w      <= '0;
            update_orien_en <= 1'b0;
            retire_pc       <= '0;
            right_orien     <= 1'b0;
        end else begin
            redirect_valid <= redirect_next;
            if (redirect_next) begin
                redirect_pc <= (acc[0] && lane_mp[0]) ? lane_redirect_pc[0] : lane_redirect_pc[1];
            end
            branch_mistaken <= deq && mp_mem[rptr_reg];
            update_orien_en <= deq && (type_mem[rptr_reg] == TYPE_COND);
            // Data outputs hold their last value while the queue is empty.
            if (deq) begin
                wrong_pc     <= pc_mem[rptr_reg];
                retire_pc    <= pc_mem[rptr_reg];
                right_target <= target_mem[rptr_reg];
                ins_type_w   <= type_mem[rptr_reg];
                right_orien  <= taken_mem[rptr_reg];
            end
        end
    end

`ifdef BPU_TRAIN_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            branch_cnt  <= branch_cnt + 32'(acc[0]) + 32'(acc[1]);
            mispred_cnt <= mispred_cnt + 32'(redirect_next);
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(in_valid_0 && !in_ready) && !(in_valid_1 && !in_ready));
            assert (!(in_valid_1 && !in_valid_0));
        end
    end
`endif

endmodule
